// File: rtl/pc_call_stack_unit_pkg.sv
// Shared defaults and the next-PC source selector for the PC / call-stack unit.
package pc_pkg;

  localparam int unsigned ADDR_W_DEF    = 19;
  localparam int unsigned RESET_VEC_DEF = 0;

  typedef enum logic [1:0] {
    SRC_SEQ,
    SRC_TGT,
    SRC_POP,
    SRC_HOLD
  } pc_src_e;

endpackage

// File: rtl/pc_call_stack_unit_if.sv
// Decoder-side control and status bundle of the PC / call-stack unit.
interface pc_call_stack_unit_if #(
  parameter int unsigned ADDR_W      = 19,
  parameter int unsigned STACK_DEPTH = 16
);
  localparam int unsigned DW = $clog2(STACK_DEPTH + 1);

  logic              stall;
  logic [ADDR_W-1:0] pc_in;
  logic [ADDR_W-1:0] target;
  logic              branch;
  logic              jump;
  logic              call;
  logic              ret;
  logic              clr_err;
  logic [ADDR_W-1:0] pc_out;
  logic [DW-1:0]     depth;
  logic              stk_full;
  logic              stk_empty;
  logic              ovf_err;
  logic              udf_err;

  modport master (
    output stall, pc_in, target, branch, jump, call, ret, clr_err,
    input  pc_out, depth, stk_full, stk_empty, ovf_err, udf_err
  );

  modport slave (
    input  stall, pc_in, target, branch, jump, call, ret, clr_err,
    output pc_out, depth, stk_full, stk_empty, ovf_err, udf_err
  );

endinterface

// File: rtl/pc_call_stack_unit_ret_stack.sv
// Bounded LIFO of return addresses; push when full and pop when empty are dropped.
module pc_ret_stack #(
  parameter int unsigned ADDR_W      = 19,
  parameter int unsigned STACK_DEPTH = 16
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               push_i,
  input  logic                               pop_i,
  input  logic [ADDR_W-1:0]                  data_i,
  output logic [ADDR_W-1:0]                  top_o,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   depth_o,
  output logic                               full_o,
  output logic                               empty_o
);
  localparam int unsigned DW = $clog2(STACK_DEPTH + 1);
  localparam int unsigned IW = $clog2(STACK_DEPTH);

  logic [ADDR_W-1:0] mem_q [STACK_DEPTH];
  logic [DW-1:0]     depth_q, depth_d;
  logic [DW-1:0]     top_idx;
  logic              do_push, do_pop;

  assign full_o  = (depth_q == DW'(STACK_DEPTH));
  assign empty_o = (depth_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign depth_o = depth_q;

  always_comb begin
    depth_d = depth_q;
    if (do_pop)
      depth_d = depth_q - DW'(1);
    else if (do_push)
      depth_d = depth_q + DW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset)
      depth_q <= '0;
    else
      depth_q <= depth_d;
  end

  // Entries are not cleared on reset; depth alone defines what is reachable.
  always_ff @(posedge clk) begin
    if (do_push)
      mem_q[depth_q[IW-1:0]] <= data_i;
  end

  assign top_idx = depth_q - DW'(1);
  assign top_o   = mem_q[top_idx[IW-1:0]];

endmodule

// File: rtl/pc_call_stack_unit.sv
// Program-counter unit: priority next-PC select, return-address stack, sticky error flags.
module pc_call_stack_unit
  import pc_pkg::*;
#(
  parameter int unsigned       ADDR_W      = ADDR_W_DEF,
  parameter int unsigned       STACK_DEPTH = 16,
  parameter logic [ADDR_W-1:0] RESET_VEC   = ADDR_W'(RESET_VEC_DEF)
) (
  input  logic                  clk,
  input  logic                  reset,
  pc_call_stack_unit_if.slave   bus
);
  localparam int unsigned DW = $clog2(STACK_DEPTH + 1);

  pc_src_e           src;
  logic [ADDR_W-1:0] pc_q, pc_d, ret_addr, stk_top;
  logic              ovf_q, ovf_d, udf_q, udf_d;
  logic              push, pop, ovf_set, udf_set;
  logic [DW-1:0]     stk_depth;
  logic              stk_full, stk_empty;

  assign ret_addr = pc_q + ADDR_W'(1);

  pc_ret_stack #(
    .ADDR_W      (ADDR_W),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (ret_addr),
    .top_o   (stk_top),
    .depth_o (stk_depth),
    .full_o  (stk_full),
    .empty_o (stk_empty)
  );

  // One-hot priority ret > call > branch > jump > sequential; stall freezes everything.
  always_comb begin
    src     = SRC_SEQ;
    push    = 1'b0;
    pop     = 1'b0;
    ovf_set = 1'b0;
    udf_set = 1'b0;
    if (bus.stall) begin
      src = SRC_HOLD;
    end else if (bus.ret) begin
      if (stk_empty) begin
        src     = SRC_HOLD;
        udf_set = 1'b1;
      end else begin
        src = SRC_POP;
        pop = 1'b1;
      end
    end else if (bus.call) begin
      if (stk_full) begin
        src     = SRC_HOLD;
        ovf_set = 1'b1;
      end else begin
        src  = SRC_TGT;
        push = 1'b1;
      end
    end else if (bus.branch || bus.jump) begin
      src = SRC_TGT;
    end
  end

  always_comb begin
    pc_d = pc_q;
    case (src)
      SRC_SEQ:  pc_d = bus.pc_in;
      SRC_TGT:  pc_d = bus.target;
      SRC_POP:  pc_d = stk_top;
      SRC_HOLD: pc_d = pc_q;
      default:  pc_d = pc_q;
    endcase
  end

  always_comb begin
    ovf_d = ovf_q;
    udf_d = udf_q;
    if (!bus.stall) begin
      ovf_d = (ovf_q & ~bus.clr_err) | ovf_set;
      udf_d = (udf_q & ~bus.clr_err) | udf_set;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q  <= RESET_VEC;
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  assign bus.pc_out    = pc_q;
  assign bus.depth     = stk_depth;
  assign bus.stk_full  = stk_full;
  assign bus.stk_empty = stk_empty;
  assign bus.ovf_err   = ovf_q;
  assign bus.udf_err   = udf_q;

endmodule

// File: tb/tb_pc_call_stack_unit.sv
// Directed scoreboard bench for pc_call_stack_unit: stimulus queues expectations, a monitor checks them.
module tb_pc_call_stack_unit;
  localparam int unsigned AW = 19;
  localparam int unsigned SD = 16;
  localparam int unsigned DW = $clog2(SD + 1);

  localparam logic [3:0] NONE = 4'b0000;
  localparam logic [3:0] RET  = 4'b1000;
  localparam logic [3:0] CALL = 4'b0100;
  localparam logic [3:0] BR   = 4'b0010;
  localparam logic [3:0] JP   = 4'b0001;

  typedef struct packed {
    logic [AW-1:0] pc;
    logic [DW-1:0] dep;
    logic          ovf;
    logic          udf;
    logic [7:0]    id;
  } exp_t;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  int   id_n;
  exp_t exp_q[$];

  pc_call_stack_unit_if #(.ADDR_W(AW), .STACK_DEPTH(SD)) bus ();

  pc_call_stack_unit #(
    .ADDR_W      (AW),
    .STACK_DEPTH (SD),
    .RESET_VEC   ('0)
  ) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic cyc(input logic st, input logic [AW-1:0] pin, input logic [AW-1:0] tgt,
                     input logic [3:0] ctl, input logic clr,
                     input logic [AW-1:0] epc, input int edep, input logic eovf, input logic eudf);
    exp_t e;
    bus.stall   = st;
    bus.pc_in   = pin;
    bus.target  = tgt;
    {bus.ret, bus.call, bus.branch, bus.jump} = ctl;
    bus.clr_err = clr;
    @(posedge clk);
    #1;
    e.pc  = epc;
    e.dep = DW'(edep);
    e.ovf = eovf;
    e.udf = eudf;
    e.id  = 8'(id_n);
    id_n++;
    exp_q.push_back(e);
  endtask

  // Monitor: one queued expectation per clock, checked on the falling edge.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_t e;
      logic ef, ee;
      e  = exp_q.pop_front();
      ef = (e.dep == DW'(SD));
      ee = (e.dep == '0);
      total++;
      if (bus.pc_out !== e.pc || bus.depth !== e.dep || bus.stk_full !== ef ||
          bus.stk_empty !== ee || bus.ovf_err !== e.ovf || bus.udf_err !== e.udf) begin
        bad++;
        $display("FAIL chk%0d: got pc=%h depth=%0d full=%b empty=%b ovf=%b udf=%b, want pc=%h depth=%0d full=%b empty=%b ovf=%b udf=%b",
                 e.id, bus.pc_out, bus.depth, bus.stk_full, bus.stk_empty, bus.ovf_err, bus.udf_err,
                 e.pc, e.dep, ef, ee, e.ovf, e.udf);
      end
    end
  end

  initial begin
    total = 0;
    bad   = 0;
    id_n  = 0;
    rst   = 1'b1;
    bus.stall = 1'b0; bus.pc_in = '0; bus.target = '0;
    bus.branch = 1'b0; bus.jump = 1'b0; bus.call = 1'b0; bus.ret = 1'b0; bus.clr_err = 1'b0;

    // reset, then sequential fetch
    cyc(0, 19'h55, 19'h0, NONE, 0, 19'h0, 0, 0, 0);
    rst = 1'b0;
    cyc(0, 19'h1, 19'h0, NONE, 0, 19'h1, 0, 0, 0);
    cyc(0, 19'h2, 19'h0, NONE, 0, 19'h2, 0, 0, 0);
    cyc(0, 19'h3, 19'h0, NONE, 0, 19'h3, 0, 0, 0);

    // single call / ret
    cyc(0, 19'h0, 19'h10,  JP,   0, 19'h10,  0, 0, 0);
    cyc(0, 19'h0, 19'h100, CALL, 0, 19'h100, 1, 0, 0);
    cyc(0, 19'h0, 19'h0,   RET,  0, 19'h11,  0, 0, 0);

    // fill the stack, overflow, then unwind in LIFO order
    for (int i = 0; i < 16; i++)
      cyc(0, 19'h0, AW'(32'h300 + 2 * i), CALL, 0, AW'(32'h300 + 2 * i), i + 1, 0, 0);
    cyc(0, 19'h0, 19'h999, CALL, 0, 19'h31E, 16, 1, 0);
    for (int k = 15; k >= 0; k--)
      cyc(0, 19'h0, 19'h5, RET, 0, (k == 0) ? 19'h12 : AW'(32'h300 + 2 * k - 1), k, 1, 0);

    // underflow, clear, clear racing a new error
    cyc(0, 19'h40, 19'h0, RET,  0, 19'h12, 0, 1, 1);
    cyc(0, 19'h13, 19'h0, NONE, 1, 19'h13, 0, 0, 0);
    cyc(0, 19'h44, 19'h0, RET,  1, 19'h13, 0, 0, 1);
    cyc(0, 19'h14, 19'h0, NONE, 1, 19'h14, 0, 0, 0);

    // priority, stall, back-to-back call/ret, branch
    cyc(0, 19'h0, 19'h400, CALL,             0, 19'h400, 1, 0, 0);
    cyc(0, 19'h0, 19'h500, CALL,             0, 19'h500, 2, 0, 0);
    cyc(0, 19'h0, 19'h777, RET | CALL | BR,  0, 19'h401, 1, 0, 0);
    cyc(1, 19'h9, 19'h888, CALL,             0, 19'h401, 1, 0, 0);
    cyc(0, 19'h0, 19'h600, CALL,             0, 19'h600, 2, 0, 0);
    cyc(0, 19'h0, 19'h0,   RET,              0, 19'h402, 1, 0, 0);
    cyc(0, 19'h0, 19'h50,  BR,               0, 19'h50,  1, 0, 0);

    // return address wraps at all-ones
    cyc(0, 19'h0, 19'h7FFFF, JP,   0, 19'h7FFFF, 1, 0, 0);
    cyc(0, 19'h0, 19'h60,    CALL, 0, 19'h60,    2, 0, 0);
    cyc(0, 19'h1, 19'h0,     RET,  0, 19'h0,     1, 0, 0);
    cyc(0, 19'h0, 19'h0,     RET,  0, 19'h15,    0, 0, 0);
    cyc(0, 19'h0, 19'h0,     RET,  0, 19'h15,    0, 0, 1);

    // reset overrides stall at depth 5 with a flag set
    for (int i = 0; i < 5; i++)
      cyc(0, 19'h0, AW'(32'h700 + 16 * i), CALL, 0, AW'(32'h700 + 16 * i), i + 1, 0, 1);
    rst = 1'b1;
    cyc(1, 19'h3, 19'h900, CALL, 0, 19'h0, 0, 0, 0);
    rst = 1'b0;
    cyc(0, 19'h7, 19'h0, RET,  0, 19'h0, 0, 0, 1);
    cyc(1, 19'h8, 19'h0, NONE, 1, 19'h0, 0, 0, 1);

    for (int i = 0; i < 10 && exp_q.size() != 0; i++)
      @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
